mdu_sequencer: RTL
==================

# mdu_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair in the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage, runs a 32-iteration shift-add or restoring-divide loop, and commits the result to HiLoReg with a one-cycle write pulse. It also drives a stall request to the hazard unit while a later HI/LO consumer would otherwise read stale values.

## Interface
- WIDTH, 32: operand width. Only 32 is supported and verified.
- Clk  in  1  pipeline clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  EX-stage mult/div issue; sampled only in IDLE or DONE.
- Op  in  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- A  in  32  forwarded rs operand (multiplicand / dividend).
- B  in  32  forwarded rt operand (multiplier / divisor).
- Flush  in  1  abort the in-flight operation (branch/jump flush).
- HiLoUse  in  1  ID-stage instruction reads or writes HI/LO (mfhi, mflo, mthi, mtlo, mult/div).
- Busy  out  1  registered; high in any state except IDLE.
- Stall  out  1  combinational stall request to the hazard unit.
- Hi_out  out  32  registered HI result.
- Lo_out  out  32  registered LO result.
- Hi_Write  out  1  one-cycle HI write strobe.
- Lo_Write  out  1  one-cycle LO write strobe; always equal to Hi_Write.
- DivZero  out  1  one-cycle flag for a divide by zero, coincident with the write strobe.

## Operation
- The FSM has four states: IDLE, RUN, FIX and DONE.
  - IDLE: Start=1 and Flush=0 latches Op, |A| and |B| (magnitudes are taken when the op is signed), clears the 6-bit counter and moves to RUN.
  - RUN: one iteration per cycle and the counter increments. After the iteration with counter=31 the FSM moves to FIX.
    - Multiply: 64-bit shift-add. If the current multiplier LSB is 1, add the multiplicand into the upper half, then shift right 1.
    - Divide: restoring. Shift the remainder:quotient pair left, trial-subtract the divisor, and keep the result and set the quotient bit if it is non-negative.
  - FIX: apply sign correction, then load Hi_out and Lo_out and move to DONE.
    - Product sign is sA^sB and negates the full 64-bit result.
    - Quotient sign is sA^sB; remainder sign is sA.
  - DONE: Hi_Write=Lo_Write=1 for exactly this cycle. Go to IDLE, or to RUN if a new Start is accepted this cycle; the write still occurs.
- Results:
  - MULT/MULTU: Hi = product[63:32], Lo = product[31:0].
  - DIV/DIVU: Lo = quotient, Hi = remainder.
- Divide by zero:
  - The operation runs the full length.
  - Hi = original A, Lo = 32'hFFFFFFFF, DivZero=1 during DONE.
- 0x80000000 / -1 (signed): Lo = 0x80000000, Hi = 0. This is the natural truncation; no trap.
- Start while in RUN or FIX is ignored. The hazard unit guarantees it never happens; the bench checks that it is ignored.
- Flush in any state returns the FSM to IDLE on the next edge with no write and no DivZero. Flush beats a simultaneous Start.
- Stall = HiLoUse & (Busy | (Start & ~Flush & state==IDLE)).

## Timing
- Reset (Rst=0) takes effect immediately, regardless of Clk:
  - state = IDLE;
  - Busy, Hi_Write, Lo_Write and DivZero = 0;
  - Hi_out and Lo_out = 0;
  - counter = 0.
- Reset mid-operation discards all work.
- Latency: Start is sampled at edge E0. RUN covers edges E1..E32, FIX is at E33, and DONE is the cycle after E33. HiLoReg captures the result at E34, a fixed 34 cycles for every op and operand value.
- Busy rises the cycle after E0 and falls the cycle after E34 unless back-to-back issue.
- Back-to-back issue: Start accepted in DONE gives the next write strobe exactly 34 cycles after that DONE edge.
- Stall is combinational from HiLoUse, Start and Flush. There is no registered delay, so the hazard unit freezes IF/ID in the same cycle.

## Configuration
- MDU_SIGNED_EN
  - Defined: MULT and DIV perform signed arithmetic with magnitude conversion and FIX-state sign correction as above.
  - Undefined: Op[1] is ignored and all operations are unsigned. The FIX state still occupies one cycle so latency stays 34 cycles.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi_out=0xFFFFFFFE, Lo_out=0x00000001. Hi_Write and Lo_Write high exactly in the cycle before E34, Busy high for 34 cycles.
- MULT A=0xFFFFFFFD (-3), B=5:
  - with MDU_SIGNED_EN -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1;
  - without it -> Hi=0x00000004, Lo=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=100, B=7 -> Lo=14, Hi=2.
- DIVU A=0x64, B=0 -> Hi=0x64, Lo=0xFFFFFFFF, DivZero=1 for one cycle coincident with the write strobe.
- Start DIVU, assert Flush at cycle 10 -> no write strobe ever, Busy=0 the next cycle. A new Start at cycle 12 completes normally 34 cycles later.
- Hold HiLoUse=1 throughout a MULTU:
  - Stall=1 from the Start cycle through DONE, then 0 once in IDLE.
  - Rst pulsed low at cycle 20 -> Busy, Stall and all outputs drop to 0 asynchronously and no write follows.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative 32-cycle multiply/divide sequencer owning the MIPS HI/LO pair.
// Define MDU_SIGNED_EN to enable signed MULT/DIV; otherwise every op is unsigned.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             HiLoUse,
    output logic             Busy,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out,
    output logic             Hi_Write,
    output logic             Lo_Write,
    output logic             DivZero
);

`ifdef MDU_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   a_orig_q, a_orig_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic               accept;

    function automatic logic [WIDTH-1:0] cneg_w(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    assign signed_op = Op[1] & SIGNED_EN;
    assign a_neg     = signed_op & A[WIDTH-1];
    assign b_neg     = signed_op & B[WIDTH-1];
    assign a_mag     = cneg_w(a_neg, A);
    assign b_mag     = cneg_w(b_neg, B);

    // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign trial    = {1'b0, rem_sh} - {2'b00, m_q};
    assign div_next = trial[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign prod_fix = cneg_2w(sa_q ^ sb_q, acc_q);

    assign accept = Start & ~Flush & ((state_q == IDLE) | (state_q == DONE));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_orig_d = a_orig_q;
        m_d      = m_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    div_d    = Op[0];
                    sa_d     = a_neg;
                    sb_d     = b_neg;
                    a_orig_d = A;
                    m_d      = Op[0] ? b_mag : a_mag;
                    acc_d    = {{WIDTH{1'b0}}, (Op[0] ? a_mag : b_mag)};
                end
            end
            RUN: begin
                acc_d = div_q ? div_next : mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                dz_d    = div_q & (m_q == '0);
                if (!div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (m_q == '0) begin
                    hi_d = a_orig_q;
                    lo_d = '1;
                end else begin
                    hi_d = cneg_w(sa_q, acc_q[2*WIDTH-1:WIDTH]);
                    lo_d = cneg_w(sa_q ^ sb_q, acc_q[WIDTH-1:0]);
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush abandons any work, including a restart offered in DONE
        if (Flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge Clk) begin
        a_orig_q <= a_orig_d;
        m_q      <= m_d;
        acc_q    <= acc_d;
    end

    assign Busy     = (state_q != IDLE);
    assign Hi_Write = (state_q == DONE) & ~Flush;
    assign Lo_Write = Hi_Write;
    assign DivZero  = Hi_Write & dz_q;
    assign Hi_out   = hi_q;
    assign Lo_out   = lo_q;
    assign Stall    = HiLoUse & (Busy | (Start & ~Flush & (state_q == IDLE)));

endmodule
